// File: rtl/sfr_addr_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : sfr_addr_gen_if
// Description : Operand-address bus between the address sequencer and the
//               systolic array / on-chip buffers. The sequencer drives the
//               address pair, valid flag and channel markers; the array
//               back-pressures with stall.
// Revision    : 1.0 - initial release
// ============================================================================
interface sfr_addr_gen_if #(
  parameter int A_ADDR_W = 19,
  parameter int W_ADDR_W = 15
);
  logic [A_ADDR_W-1:0] a_addr;
  logic [W_ADDR_W-1:0] w_addr;
  logic                addr_valid;
  logic                first_ch;
  logic                last_ch;
  logic                stall;

  // Sequencer side
  modport master (
    output a_addr,
    output w_addr,
    output addr_valid,
    output first_ch,
    output last_ch,
    input  stall
  );

  // Array / buffer side
  modport slave (
    input  a_addr,
    input  w_addr,
    input  addr_valid,
    input  first_ch,
    input  last_ch,
    output stall
  );
endinterface
`default_nettype wire

// File: rtl/sfr_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : sfr_addr_gen
// Description : Operand-address sequencer for the systolic CNN array. Walks
//               reduction channels inside output tiles and emits one
//               activation/weight address pair per accepted (non-stalled)
//               cycle, with first/last channel markers for accumulator
//               clear and writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module sfr_addr_gen #(
  parameter int A_ADDR_W = 19,
  parameter int W_ADDR_W = 15,
  parameter int CNT_W    = 10,
  parameter int TILE_W   = 8
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                start,
  input  wire logic                abort,
  input  wire logic [A_ADDR_W-1:0] cfg_a_base,
  input  wire logic [W_ADDR_W-1:0] cfg_w_base,
  input  wire logic [A_ADDR_W-1:0] cfg_a_stride,
  input  wire logic [W_ADDR_W-1:0] cfg_w_stride,
  input  wire logic [A_ADDR_W-1:0] cfg_a_tile_stride,
  input  wire logic [W_ADDR_W-1:0] cfg_w_tile_stride,
  input  wire logic [CNT_W-1:0]    cfg_ch_last,
  input  wire logic [TILE_W-1:0]   cfg_tile_last,
  output logic                     busy,
  output logic                     done,
  sfr_addr_gen_if.master           bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;

  // Configuration snapshot taken at launch; live cfg inputs are ignored after.
  logic [A_ADDR_W-1:0] r_a_stride;
  logic [W_ADDR_W-1:0] r_w_stride;
  logic [A_ADDR_W-1:0] r_a_tile_stride;
  logic [W_ADDR_W-1:0] r_w_tile_stride;
  logic [CNT_W-1:0]    r_ch_last;
  logic [TILE_W-1:0]   r_tile_last;

  // Walk state
  logic [CNT_W-1:0]    r_ch;
  logic [TILE_W-1:0]   r_tile;
  logic [A_ADDR_W-1:0] r_a_tile_base;
  logic [W_ADDR_W-1:0] r_w_tile_base;
  logic [A_ADDR_W-1:0] r_a_addr;
  logic [W_ADDR_W-1:0] r_w_addr;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;

  // Sums truncate to the port width, so addresses wrap without saturation.
  logic [A_ADDR_W-1:0] w_a_next_base;
  logic [W_ADDR_W-1:0] w_w_next_base;
  logic                w_ch_end;
  logic                w_tile_end;

  assign w_a_next_base = r_a_tile_base + r_a_tile_stride;
  assign w_w_next_base = r_w_tile_base + r_w_tile_stride;
  assign w_ch_end      = (r_ch == r_ch_last);
  assign w_tile_end    = (r_tile == r_tile_last);

  // Sequencer FSM: launch, channel/tile walk under stall, completion and cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_a_stride      <= '0;
      r_w_stride      <= '0;
      r_a_tile_stride <= '0;
      r_w_tile_stride <= '0;
      r_ch_last       <= '0;
      r_tile_last     <= '0;
      r_ch            <= '0;
      r_tile          <= '0;
      r_a_tile_base   <= '0;
      r_w_tile_base   <= '0;
      r_a_addr        <= '0;
      r_w_addr        <= '0;
      r_valid         <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_a_stride      <= cfg_a_stride;
            r_w_stride      <= cfg_w_stride;
            r_a_tile_stride <= cfg_a_tile_stride;
            r_w_tile_stride <= cfg_w_tile_stride;
            r_ch_last       <= cfg_ch_last;
            r_tile_last     <= cfg_tile_last;
            r_ch            <= '0;
            r_tile          <= '0;
            r_a_tile_base   <= cfg_a_base;
            r_w_tile_base   <= cfg_w_base;
            r_a_addr        <= cfg_a_base;
            r_w_addr        <= cfg_w_base;
            r_valid         <= 1'b1;
            r_busy          <= 1'b1;
            r_state         <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (!bus.stall) begin
            if (!w_ch_end) begin
              r_ch     <= r_ch + CNT_W'(1);
              r_a_addr <= r_a_addr + r_a_stride;
              r_w_addr <= r_w_addr + r_w_stride;
            end else if (!w_tile_end) begin
              r_ch          <= '0;
              r_tile        <= r_tile + TILE_W'(1);
              r_a_tile_base <= w_a_next_base;
              r_w_tile_base <= w_w_next_base;
              r_a_addr      <= w_a_next_base;
              r_w_addr      <= w_w_next_base;
            end else begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Markers are decoded only from registered state, never from stall.
  assign bus.a_addr     = r_a_addr;
  assign bus.w_addr     = r_w_addr;
  assign bus.addr_valid = r_valid;
  assign bus.first_ch   = r_valid & (r_ch == '0);
  assign bus.last_ch    = r_valid & w_ch_end;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sfr_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sfr_addr_gen
// Description : Scoreboard bench for sfr_addr_gen. Each job's expected beat
//               list is computed from the nested-loop address formula and
//               queued; a negedge monitor pops and compares on every
//               accepted beat and on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sfr_addr_gen;

  localparam int AW = 19;
  localparam int WW = 15;
  localparam int CW = 10;
  localparam int TW = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW-1:0] cfg_a_base;
  logic [WW-1:0] cfg_w_base;
  logic [AW-1:0] cfg_a_stride;
  logic [WW-1:0] cfg_w_stride;
  logic [AW-1:0] cfg_a_tile_stride;
  logic [WW-1:0] cfg_w_tile_stride;
  logic [CW-1:0] cfg_ch_last;
  logic [TW-1:0] cfg_tile_last;
  logic          busy;
  logic          done;

  sfr_addr_gen_if #(.A_ADDR_W(AW), .W_ADDR_W(WW)) bus ();

  sfr_addr_gen #(
    .A_ADDR_W(AW), .W_ADDR_W(WW), .CNT_W(CW), .TILE_W(TW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .cfg_a_base       (cfg_a_base),
    .cfg_w_base       (cfg_w_base),
    .cfg_a_stride     (cfg_a_stride),
    .cfg_w_stride     (cfg_w_stride),
    .cfg_a_tile_stride(cfg_a_tile_stride),
    .cfg_w_tile_stride(cfg_w_tile_stride),
    .cfg_ch_last      (cfg_ch_last),
    .cfg_tile_last    (cfg_tile_last),
    .busy             (busy),
    .done             (done),
    .bus              (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [AW-1:0] a;
    logic [WW-1:0] w;
    bit          first;
    bit          last;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: every accepted beat and every done pulse consumes one queue entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.addr_valid && !bus.stall && !abort) begin
        if (q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          e = q.pop_front();
          chk("beat_kind", {31'd0, e.is_done}, 0);
          chk("a_addr", bus.a_addr, e.a);
          chk("w_addr", bus.w_addr, e.w);
          chk("first_ch", bus.first_ch, e.first);
          chk("last_ch", bus.last_ch, e.last);
          chk("busy_in_run", busy, 1);
        end
      end
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("done_kind", {31'd0, e.is_done}, 1);
          chk("valid_at_done", bus.addr_valid, 0);
          chk("busy_at_done", busy, 0);
        end
      end
    end
  end

  task automatic check_idle(input bit with_addr);
    chk("idle_valid", bus.addr_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_first", bus.first_ch, 0);
    chk("idle_last", bus.last_ch, 0);
    if (with_addr) begin
      chk("idle_a_addr", bus.a_addr, 0);
      chk("idle_w_addr", bus.w_addr, 0);
    end
  endtask

  // mode 0: full run, 1: abort after stop_n beats, 2: rst after stop_n beats
  task automatic run_job(input logic [AW-1:0] ab, input logic [AW-1:0] as_, input logic [AW-1:0] ats,
                         input logic [WW-1:0] wb, input logic [WW-1:0] ws_, input logic [WW-1:0] wts,
                         input logic [CW-1:0] chl, input logic [TW-1:0] tl,
                         input bit rnd_stall, input logic [31:0] smask,
                         input int mode, input int stop_n);
    int total, n_push, idx, cyc, beats;
    bit s;
    exp_t e;
    total  = (int'(chl) + 1) * (int'(tl) + 1);
    n_push = (mode == 0) ? total : stop_n;
    idx = 0;
    for (int t = 0; t <= int'(tl); t++) begin
      for (int c = 0; c <= int'(chl); c++) begin
        longint unsigned av, wv;
        av = longint'(ab) + longint'(t) * longint'(ats) + longint'(c) * longint'(as_);
        wv = longint'(wb) + longint'(t) * longint'(wts) + longint'(c) * longint'(ws_);
        if (idx < n_push) begin
          e.is_done = 0; e.a = av[AW-1:0]; e.w = wv[WW-1:0];
          e.first = (c == 0); e.last = (c == int'(chl));
          q.push_back(e);
        end
        idx++;
      end
    end
    if (mode == 0) begin
      e.is_done = 1; e.a = '0; e.w = '0; e.first = 0; e.last = 0;
      q.push_back(e);
    end

    cfg_a_base = ab; cfg_a_stride = as_; cfg_a_tile_stride = ats;
    cfg_w_base = wb; cfg_w_stride = ws_; cfg_w_tile_stride = wts;
    cfg_ch_last = chl; cfg_tile_last = tl;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble live config: the run must use the launch snapshot.
    cfg_a_base = AW'($urandom); cfg_a_stride = AW'($urandom); cfg_a_tile_stride = AW'($urandom);
    cfg_w_base = WW'($urandom); cfg_w_stride = WW'($urandom); cfg_w_tile_stride = WW'($urandom);
    cfg_ch_last = CW'($urandom); cfg_tile_last = TW'($urandom);

    cyc = 1; beats = 0;
    while (beats < total) begin
      if (mode != 0 && beats == stop_n) break;
      s = rnd_stall ? ($urandom_range(0, 3) == 0) : ((cyc < 32) ? smask[cyc] : 1'b0);
      bus.stall = s;
      start = ($urandom_range(0, 4) == 0);
      @(posedge clk); #1;
      cyc++;
      if (!s) beats++;
    end
    bus.stall = 1'b0;
    start = 1'b0;

    if (mode == 0) begin
      start = 1'b1;                       // start in DONE must be ignored
      @(negedge clk);
      chk("done_cycle", done, 1);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin @(negedge clk); check_idle(0); end
    end else if (mode == 1) begin
      abort = 1'b1;
      start = $urandom_range(0, 1);
      bus.stall = $urandom_range(0, 1);
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0; bus.stall = 1'b0;
      repeat (3) begin @(negedge clk); check_idle(0); end
    end else begin
      rst = 1'b1;
      #1;
      check_idle(1);
      repeat (2) begin @(posedge clk); #1; start = ~start; end
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      repeat (3) begin @(negedge clk); check_idle(1); end
    end
    @(posedge clk); #1;
    chk("queue_drained", q.size(), 0);
    q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; bus.stall = 1'b0;
    cfg_a_base = '0; cfg_w_base = '0; cfg_a_stride = '0; cfg_w_stride = '0;
    cfg_a_tile_stride = '0; cfg_w_tile_stride = '0; cfg_ch_last = '0; cfg_tile_last = '0;

    // Reset with start toggling, then idle with no start.
    repeat (4) begin @(posedge clk); #1; start = ~start; @(negedge clk); check_idle(1); end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (4) begin @(negedge clk); check_idle(1); end
    @(posedge clk); #1;

    // Single tile, no stall
    run_job(19'd100, 19'd784, 19'd5, 15'd0, 15'd1, 15'd9, 10'd3, 8'd0, 0, 32'd0, 0, 0);
    // Same with stall on cycles 2-3
    run_job(19'd100, 19'd784, 19'd5, 15'd0, 15'd1, 15'd9, 10'd3, 8'd0, 0, 32'b1100, 0, 0);
    // Multi-tile
    run_job(19'd0, 19'd10, 19'd1, 15'd0, 15'd1, 15'd2, 10'd1, 8'd2, 0, 32'd0, 0, 0);
    // Wrap-around
    run_job(19'h7FFFE, 19'd3, 19'd0, 15'h7FFF, 15'd2, 15'd0, 10'd1, 8'd0, 0, 32'd0, 0, 0);
    // Single channel per tile: first and last on every beat
    run_job(19'd7, 19'd1, 19'd50, 15'd3, 15'd1, 15'd40, 10'd0, 8'd3, 0, 32'b1010, 0, 0);
    // Abort on beat 2
    run_job(19'd100, 19'd784, 19'd5, 15'd0, 15'd1, 15'd9, 10'd3, 8'd1, 0, 32'd0, 1, 1);
    // start + abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (3) begin @(negedge clk); check_idle(0); end
    @(posedge clk); #1;
    // rst on beat 3, then restart from bases
    run_job(19'd100, 19'd784, 19'd5, 15'd0, 15'd1, 15'd9, 10'd3, 8'd1, 0, 32'd0, 2, 2);
    run_job(19'd100, 19'd784, 19'd5, 15'd0, 15'd1, 15'd9, 10'd3, 8'd1, 0, 32'd0, 0, 0);

    // Randomized jobs with random stall, including random aborts
    for (int k = 0; k < 24; k++) begin
      int m, sn;
      logic [CW-1:0] chl;
      logic [TW-1:0] tl;
      chl = CW'($urandom_range(0, 5));
      tl  = TW'($urandom_range(0, 3));
      m   = ($urandom_range(0, 5) == 0) ? 1 : 0;
      sn  = $urandom_range(0, (int'(chl) + 1) * (int'(tl) + 1) - 1);
      run_job(AW'($urandom), AW'($urandom), AW'($urandom),
              WW'($urandom), WW'($urandom), WW'($urandom),
              chl, tl, 1, 32'd0, m, sn);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sfr_addr_gen.md
# sfr_addr_gen

Parametrised operand-address sequencer for the systolic-array CNN accelerator. On `start` it walks a two-level loop (reduction channels inside output tiles) and streams one activation address and one weight address per accepted cycle to the on-chip buffers. Each advance is gated by a valid/stall handshake with the array. Per-beat first/last markers drive accumulator clear and writeback. Channel count, strides, tile count and bases are run-time configuration, not constants.

## Interface
- `A_ADDR_W`, 19, activation address width
- `W_ADDR_W`, 15, weight address width
- `CNT_W`, 10, channel-counter width (max 2^CNT_W channels per tile)
- `TILE_W`, 8, tile-counter width

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  launch pulse; sampled only in IDLE
- `abort`  in  1  synchronous cancel; returns to IDLE
- `cfg_a_base`  in  A_ADDR_W  first activation address
- `cfg_w_base`  in  W_ADDR_W  first weight address
- `cfg_a_stride`  in  A_ADDR_W  activation step per channel (e.g. 784 = 28×28)
- `cfg_w_stride`  in  W_ADDR_W  weight step per channel
- `cfg_a_tile_stride`  in  A_ADDR_W  activation step per tile, applied to the tile base
- `cfg_w_tile_stride`  in  W_ADDR_W  weight step per tile, applied to the tile base
- `cfg_ch_last`  in  CNT_W  channels per tile minus 1
- `cfg_tile_last`  in  TILE_W  tiles minus 1
- `stall`  in  1  array cannot accept this cycle
- `a_addr`  out  A_ADDR_W  current activation address
- `w_addr`  out  W_ADDR_W  current weight address
- `addr_valid`  out  1  address pair is valid
- `first_ch`  out  1  current beat is channel 0 of its tile
- `last_ch`  out  1  current beat is channel `cfg_ch_last`
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse after the final transfer

## Operation
- States are IDLE, RUN and DONE.
- IDLE → RUN when `start`=1 and `abort`=0.
  - All `cfg_*` inputs are latched that cycle and are ignored afterwards.
  - Counters `ch`=0 and `tile`=0; `a_addr`=`cfg_a_base`; `w_addr`=`cfg_w_base`.
  - Tile base registers are loaded with the same two bases.
- Transfer: any cycle in RUN with `stall`=0. Exactly one address pair is consumed per transfer.
- Stall: with `stall`=1 in RUN, addresses, counters and markers hold; `addr_valid` stays 1.
- Transfer with `ch` < `cfg_ch_last`:
  - `ch`+1.
  - `a_addr` += `cfg_a_stride`; `w_addr` += `cfg_w_stride`.
- Transfer with `ch` = `cfg_ch_last` and `tile` < `cfg_tile_last`:
  - `ch`=0; `tile`+1.
  - Each tile base += its tile stride, and the address is loaded from the new tile base.
- Transfer with `ch` = `cfg_ch_last` and `tile` = `cfg_tile_last` → DONE.
- DONE → IDLE unconditionally after 1 cycle. `start` in DONE is ignored.
- `start` while in RUN is ignored.
- `abort` in RUN or DONE → IDLE next cycle. No `done` pulse is produced. `abort` overrides `start` in the same cycle.
- Arithmetic: all address sums are unsigned and truncated to the port width, so they wrap modulo 2^A_ADDR_W and 2^W_ADDR_W. No saturation.
- Decode:
  - `first_ch` = (`ch`==0) & `addr_valid`.
  - `last_ch` = (`ch`==`cfg_ch_last`) & `addr_valid`.
  - With `cfg_ch_last`=0, both are high on every beat.

## Timing
- Reset values: `a_addr`=0, `w_addr`=0, `addr_valid`=0, `first_ch`=0, `last_ch`=0, `busy`=0, `done`=0. State is IDLE and all counters are 0.
- `rst` asserted mid-run forces the reset values immediately (asynchronous). The block resumes only on a new `start` after `rst` deasserts.
- `start` sampled at edge N → `addr_valid`=1 and `busy`=1 from cycle N+1, carrying the base addresses.
- With no stall, transfers occur on consecutive cycles.
- Total run length is (`cfg_ch_last`+1)·(`cfg_tile_last`+1) transfers plus the number of stalled cycles.
- `done`=1 in the cycle after the final transfer. In that cycle `addr_valid`=0 and `busy`=0.
- The earliest re-`start` is accepted the cycle after `done`.
- All outputs are registered or decoded only from registered state. There is no combinational path from `stall` to any output.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst` with `start` toggling.
  - Required: all outputs 0. After release with no `start`, outputs stay 0 indefinitely.
- Single tile:
  - Stimulus: a_base=100, a_stride=784, w_base=0, w_stride=1, ch_last=3, tile_last=0, no stall.
  - Required: `a_addr` = 100, 884, 1668, 2452 and `w_addr` = 0..3 on cycles 1-4. `first_ch` on cycle 1, `last_ch` on cycle 4, `done` on cycle 5.
- Stall handling:
  - Stimulus: same configuration as the single-tile case, `stall`=1 on cycles 2-3.
  - Required: address 884/1 is held for 3 cycles and the sequence then resumes. `done` on cycle 7; no beat skipped or duplicated.
- Multi-tile:
  - Stimulus: ch_last=1, tile_last=2, a_base=0, a_stride=10, a_tile_stride=1, w_base=0, w_stride=1, w_tile_stride=2.
  - Required: `a_addr` = 0, 10, 1, 11, 2, 12 and `w_addr` = 0, 1, 2, 3, 4, 5. `last_ch` is high on beats 2, 4 and 6.
- Wrap-around:
  - Stimulus: a_base=2^19−2, a_stride=3, ch_last=1.
  - Required: second `a_addr` = 1.
- Control corners:
  - Stimulus: `start` pulsed during RUN; `abort` on beat 2; `start` and `abort` together in IDLE; `rst` asserted on beat 3 of a run.
  - Required:
    - `start` during RUN is ignored.
    - `abort` returns to IDLE with no `done`.
    - `start`+`abort` together in IDLE stays in IDLE.
    - `rst` mid-run clears all outputs, and a subsequent `start` restarts from the bases.
